// File: rtl/pong_collision_scorer.sv
// Per-frame collision classifier and score keeper for Pong. Paddle hits, wall
// hits and misses are resolved on each frame_tick; the serve/game-over
// sequence runs over a serve_req/serve_ack handshake.
`timescale 1ns/1ps

module pong_collision_scorer #(
  parameter int X_W       = 6,
  parameter int Y_W       = 6,
  parameter int FIELD_H   = 64,
  parameter int PADDLE_H  = 6,
  parameter int P1_X      = 2,
  parameter int P2_X      = 61,
  parameter int SCORE_W   = 4,
  parameter int WIN_SCORE = 9,
  parameter int SERVE_DLY = 60
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic [X_W-1:0]     bx,
  input  logic [Y_W-1:0]     by,
  input  logic [Y_W-1:0]     p1y,
  input  logic [Y_W-1:0]     p2y,
  input  logic               start,
  input  logic               serve_ack,
  output logic               hit_l,
  output logic               hit_r,
  output logic               wall_hit,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               serve_req,
  output logic               serve_dir,
  output logic               game_over,
  output logic               winner
);

  // state | meaning
  // IDLE  | waiting for start after reset
  // SERVE | serve_req high, waiting for serve_ack
  // PLAY  | classifying the ball on every frame_tick
  // PAUSE | counting SERVE_DLY frame_ticks after a point
  // OVER  | a player reached WIN_SCORE, waiting for start
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam int CNT_W = (SERVE_DLY > 1) ? $clog2(SERVE_DLY) : 1;

  localparam logic [X_W-1:0]     P1_XV    = X_W'(P1_X);
  localparam logic [X_W-1:0]     P2_XV    = X_W'(P2_X);
  localparam logic [Y_W-1:0]     BOT_ROW  = Y_W'(FIELD_H - 1);
  localparam logic [Y_W:0]       PAD_SPAN = (Y_W + 1)'(PADDLE_H - 1);
  localparam logic [SCORE_W-1:0] WIN_V    = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_1  = SCORE_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_DLY - 1);
  localparam logic [CNT_W-1:0]   CNT_1    = CNT_W'(1);

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic [SCORE_W-1:0] score2_q, score2_d;
  logic               hit_l_q, hit_l_d;
  logic               hit_r_q, hit_r_d;
  logic               wall_hit_q, wall_hit_d;
  logic               serve_req_q, serve_req_d;
  logic               serve_dir_q, serve_dir_d;
  logic               game_over_q, game_over_d;
  logic               winner_q, winner_d;

  // Range test one bit wider than y so a paddle near the bottom does not wrap.
  logic [Y_W:0] by_x, p1_lo, p1_hi, p2_lo, p2_hi;
  logic         in_p1, in_p2, at_p1, at_p2, on_wall;
  logic [SCORE_W-1:0] score1_inc, score2_inc;

  assign by_x    = {1'b0, by};
  assign p1_lo   = {1'b0, p1y};
  assign p2_lo   = {1'b0, p2y};
  assign p1_hi   = p1_lo + PAD_SPAN;
  assign p2_hi   = p2_lo + PAD_SPAN;
  assign in_p1   = (by_x >= p1_lo) && (by_x <= p1_hi);
  assign in_p2   = (by_x >= p2_lo) && (by_x <= p2_hi);
  assign at_p1   = (bx == P1_XV);
  assign at_p2   = (bx == P2_XV);
  assign on_wall = (by == '0) || (by == BOT_ROW);

  assign score1_inc = score1_q + SCORE_1;
  assign score2_inc = score2_q + SCORE_1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    hit_l_d     = 1'b0;
    hit_r_d     = 1'b0;
    wall_hit_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          score1_d = '0;
          score2_d = '0;
          state_d  = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (serve_ack) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (frame_tick) begin
          hit_l_d    = at_p1 && in_p1;
          hit_r_d    = at_p2 && in_p2;
          wall_hit_d = on_wall;
          // The conceding player receives the next serve.
          if (at_p1 && !in_p1) begin
            score2_d    = score2_inc;
            serve_dir_d = 1'b0;
            cnt_d       = '0;
            if (score2_inc == WIN_V) begin
              state_d  = ST_OVER;
              winner_d = 1'b1;
            end else begin
              state_d = ST_PAUSE;
            end
          end else if (at_p2 && !in_p2) begin
            score1_d    = score1_inc;
            serve_dir_d = 1'b1;
            cnt_d       = '0;
            if (score1_inc == WIN_V) begin
              state_d  = ST_OVER;
              winner_d = 1'b0;
            end else begin
              state_d = ST_PAUSE;
            end
          end
        end
      end
      ST_PAUSE: begin
        if (frame_tick) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_SERVE;
          end else begin
            cnt_d = cnt_q + CNT_1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    serve_req_d = (state_d == ST_SERVE);
    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      score1_q    <= '0;
      score2_q    <= '0;
      hit_l_q     <= 1'b0;
      hit_r_q     <= 1'b0;
      wall_hit_q  <= 1'b0;
      serve_req_q <= 1'b0;
      serve_dir_q <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      hit_l_q     <= hit_l_d;
      hit_r_q     <= hit_r_d;
      wall_hit_q  <= wall_hit_d;
      serve_req_q <= serve_req_d;
      serve_dir_q <= serve_dir_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign hit_l     = hit_l_q;
  assign hit_r     = hit_r_q;
  assign wall_hit  = wall_hit_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign serve_req = serve_req_q;
  assign serve_dir = serve_dir_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_pong_collision_scorer.sv
// Scoreboard bench for pong_collision_scorer: each driven cycle pushes the
// expected registered outputs, which are popped and compared after the edge.
`timescale 1ns/1ps

module tb_pong_collision_scorer;

  localparam int P1_X     = 2;
  localparam int P2_X     = 61;
  localparam int PADDLE_H = 6;
  localparam int FIELD_H  = 64;
  localparam int WIN      = 9;
  localparam int DLY      = 60;

  localparam int PH_IDLE  = 0;
  localparam int PH_SERVE = 1;
  localparam int PH_PLAY  = 2;
  localparam int PH_PAUSE = 3;
  localparam int PH_OVER  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       serve_ack = 1'b0;
  logic [5:0] bx = '0, by = '0, p1y = '0, p2y = '0;
  logic       hit_l, hit_r, wall_hit, serve_req, serve_dir, game_over, winner;
  logic [3:0] score1, score2;

  pong_collision_scorer dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .bx(bx), .by(by), .p1y(p1y), .p2y(p2y),
    .start(start), .serve_ack(serve_ack),
    .hit_l(hit_l), .hit_r(hit_r), .wall_hit(wall_hit),
    .score1(score1), .score2(score2),
    .serve_req(serve_req), .serve_dir(serve_dir),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hl, hr, wh, s1, s2, sreq, sdir, go, win;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;
  int ph = PH_IDLE, s1 = 0, s2 = 0, sdir = 0, win = 0, pcnt = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hit_l"}, int'(hit_l), 0);
    chk({tag, "_hit_r"}, int'(hit_r), 0);
    chk({tag, "_wall"}, int'(wall_hit), 0);
    chk({tag, "_score1"}, int'(score1), 0);
    chk({tag, "_score2"}, int'(score2), 0);
    chk({tag, "_serve_req"}, int'(serve_req), 0);
    chk({tag, "_serve_dir"}, int'(serve_dir), 0);
    chk({tag, "_game_over"}, int'(game_over), 0);
    chk({tag, "_winner"}, int'(winner), 0);
  endtask

  // One clock of stimulus; entered and left at posedge+1.
  task automatic step(input int t, input int x, input int y, input int a,
                      input int b, input int st, input int ack);
    exp_t e;
    int inl, inr;
    e.hl = 0; e.hr = 0; e.wh = 0;
    case (ph)
      PH_IDLE, PH_OVER: if (st != 0) begin s1 = 0; s2 = 0; ph = PH_SERVE; end
      PH_SERVE: if (ack != 0) ph = PH_PLAY;
      PH_PLAY: if (t != 0) begin
        inl = (y >= a && y <= a + PADDLE_H - 1) ? 1 : 0;
        inr = (y >= b && y <= b + PADDLE_H - 1) ? 1 : 0;
        e.hl = (x == P1_X && inl == 1) ? 1 : 0;
        e.hr = (x == P2_X && inr == 1) ? 1 : 0;
        e.wh = (y == 0 || y == FIELD_H - 1) ? 1 : 0;
        if (x == P1_X && inl == 0) begin
          s2++; sdir = 0; pcnt = 0;
          if (s2 == WIN) begin ph = PH_OVER; win = 1; end else ph = PH_PAUSE;
        end else if (x == P2_X && inr == 0) begin
          s1++; sdir = 1; pcnt = 0;
          if (s1 == WIN) begin ph = PH_OVER; win = 0; end else ph = PH_PAUSE;
        end
      end
      PH_PAUSE: if (t != 0) begin
        pcnt++;
        if (pcnt == DLY) ph = PH_SERVE;
      end
      default: ;
    endcase
    e.s1 = s1; e.s2 = s2; e.sdir = sdir; e.win = win;
    e.sreq = (ph == PH_SERVE) ? 1 : 0;
    e.go   = (ph == PH_OVER) ? 1 : 0;
    sb.push_back(e);

    frame_tick = t[0]; bx = x[5:0]; by = y[5:0]; p1y = a[5:0]; p2y = b[5:0];
    start = st[0]; serve_ack = ack[0];
    @(posedge clk); #1;
    frame_tick = 1'b0; start = 1'b0; serve_ack = 1'b0;

    e = sb.pop_front();
    chk("hit_l", int'(hit_l), e.hl);
    chk("hit_r", int'(hit_r), e.hr);
    chk("wall_hit", int'(wall_hit), e.wh);
    chk("score1", int'(score1), e.s1);
    chk("score2", int'(score2), e.s2);
    chk("serve_req", int'(serve_req), e.sreq);
    chk("serve_dir", int'(serve_dir), e.sdir);
    chk("game_over", int'(game_over), e.go);
    if (e.go != 0) chk("winner", int'(winner), e.win);
  endtask

  // Asynchronous reset asserted mid-cycle, checked before the next edge.
  task automatic mid_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 chk_zero(tag);
    ph = PH_IDLE; s1 = 0; s2 = 0; sdir = 0; win = 0; pcnt = 0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_zero({tag, "_post"});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 chk_zero("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // IDLE ticks at a left-paddle miss position do nothing
    step(1, P1_X, 40, 10, 10, 0, 0);
    step(1, P1_X, 40, 10, 10, 0, 1);
    step(0, 0, 30, 10, 10, 1, 0);
    step(0, 0, 30, 10, 10, 0, 0);
    step(0, 0, 30, 10, 10, 0, 1);

    // left paddle: edge row hit, one cycle pulse, then one row below misses
    step(1, P1_X, 15, 10, 30, 0, 0);
    step(0, P1_X, 15, 10, 30, 0, 0);
    step(1, P1_X, 10, 10, 30, 0, 0);
    step(1, P1_X, 16, 10, 30, 0, 0);
    step(0, 30, 30, 10, 30, 1, 1);
    for (int i = 0; i < DLY; i++) step(1, P1_X, 40, 10, 30, 0, 0);
    step(0, 30, 30, 10, 30, 1, 1);

    // right paddle at the bottom row: no wrap, and a corner miss with wall
    step(1, P2_X, 63, 10, 63, 0, 0);
    step(1, 30, 0, 10, 63, 0, 0);
    step(1, P2_X, 0, 10, 63, 0, 0);

    // run player 1 up to the winning score
    for (int k = 0; k < 20 && s1 < WIN; k++) begin
      for (int i = 0; i < DLY; i++) step(1, P2_X, 20, 10, 40, 0, 0);
      step(0, 30, 30, 10, 40, 0, 1);
      step(1, P2_X, 20, 10, 40, 0, 0);
    end
    step(1, P2_X, 20, 10, 40, 0, 0);
    step(1, P1_X, 40, 10, 40, 0, 1);
    step(0, 30, 30, 10, 40, 1, 0);
    step(0, 30, 30, 10, 40, 0, 1);

    // mid-PAUSE reset with a non-zero score
    step(1, P1_X, 40, 10, 40, 0, 0);
    for (int i = 0; i < 5; i++) step(1, P1_X, 40, 10, 40, 0, 0);
    mid_reset("rst_pause");
    step(1, P1_X, 40, 10, 40, 0, 1);

    // mid-SERVE reset, then confirm the handshake restarts from IDLE
    step(0, 30, 30, 10, 40, 1, 0);
    mid_reset("rst_serve");
    step(0, 30, 30, 10, 40, 0, 1);
    step(0, 30, 30, 10, 40, 1, 0);
    step(0, 30, 30, 10, 40, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
